// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Run-control and configuration block for serial bit-pattern detectors.
//   Holds a programmable pattern (up to MAX_LEN bits, MSB received first),
//   runs overlapping or non-overlapping detection between start/stop, counts
//   matches (saturating) and reports each match over a valid/ready event port.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   cfg_valid/cfg_ready : config handshake; ready only while idle
//   cfg_pattern/len/overlap : pattern, length (2..MAX_LEN), overlap mode
//   cfg_err             : one-cycle pulse when an offered config is rejected
//   start/stop          : enter/leave the run state
//   x, x_valid          : serial data bit and its qualifier
//   busy                : high while running
//   match               : registered pulse one cycle after a completing bit
//   match_count/overflow: saturating count since start, sticky saturation flag
//   evt_valid/ready/count : event channel carrying the count at match time
//   timeout             : watchdog pulse (only with SEQ_DET_TIMEOUT_EN)
//
// Build option
//   SEQ_DET_TIMEOUT_EN : when defined, a watchdog ends the run after TIMEOUT
//                        processed bits without a hit; otherwise timeout = 0.

module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CNT_W-1:0]   evt_count,
  output logic               timeout
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  state_t             r_state, w_state_n;
  logic [MAX_LEN-1:0] r_pat, r_hist;
  logic [3:0]         r_len, r_fill;
  logic               r_ovl, r_cfg_ok, r_cfg_err, r_match, r_ovf, r_evt_v;
  logic [CNT_W-1:0]   r_cnt, r_evt_cnt;

  logic               w_cfg_acc, w_cfg_legal, w_cfg_load, w_go, w_bit, w_hit;
  logic               w_sat, w_expire;
  logic [MAX_LEN-1:0] w_hist_n, w_mask;
  logic [3:0]         w_fill_n;
  logic [CNT_W-1:0]   w_cnt_n;

  always_comb begin
    w_cfg_acc   = cfg_valid && (r_state == S_IDLE);
    w_cfg_legal = (cfg_len >= 4'd2) && (cfg_len <= LEN_MAX);
    w_cfg_load  = w_cfg_acc && w_cfg_legal;
    // A legal config offered alongside start is usable immediately.
    w_go        = (r_state == S_IDLE) && start && (r_cfg_ok || w_cfg_load);
    w_bit       = (r_state == S_RUN) && x_valid;
    w_hist_n    = {r_hist[MAX_LEN-2:0], x};
    w_fill_n    = (r_fill == LEN_MAX) ? r_fill : r_fill + 4'd1;
    w_mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
    w_hit       = w_bit && (w_fill_n >= r_len) &&
                  (((w_hist_n ^ r_pat) & w_mask) == '0);
    w_sat       = (r_cnt == '1);
    w_cnt_n     = w_sat ? r_cnt : r_cnt + CNT_W'(1);

    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_n = S_RUN;
      S_RUN:   if (stop || w_expire) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_cfg_ok  <= 1'b0;
      r_cfg_err <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_evt_v   <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_cfg_err <= w_cfg_acc && !w_cfg_legal;
      r_match   <= w_hit;
      if (w_cfg_load) begin
        r_pat    <= cfg_pattern;
        r_len    <= cfg_len;
        r_ovl    <= cfg_overlap;
        r_cfg_ok <= 1'b1;
      end
      if (w_go) begin
        r_hist <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else if (w_bit) begin
        r_hist <= w_hist_n;
        // Non-overlapping mode restarts the window after each hit.
        r_fill <= (w_hit && !r_ovl) ? 4'd0 : w_fill_n;
        if (w_hit) begin
          r_cnt <= w_cnt_n;
          if (w_sat) r_ovf <= 1'b1;
        end
      end
      // A hit in the accept cycle reloads, keeping evt_valid high.
      if (w_hit && (!r_evt_v || evt_ready)) begin
        r_evt_v   <= 1'b1;
        r_evt_cnt <= w_cnt_n;
      end else if (r_evt_v && evt_ready) begin
        r_evt_v <= 1'b0;
      end
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;

  // Fires on the bit that would bring the count to TIMEOUT.
  assign w_expire = w_bit && !w_hit && (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_go || w_hit || w_expire) r_wdog <= '0;
      else if (w_bit)                r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_expire         = 1'b0;
  assign timeout          = 1'b0;
`endif

  assign cfg_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign cfg_err     = r_cfg_err;
  assign match       = r_match;
  assign match_count = r_cnt;
  assign overflow    = r_ovf;
  assign evt_valid   = r_evt_v;
  assign evt_count   = r_evt_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: table-driven vectors on a default-parameter
// instance plus hand sequences for saturation (CNT_W=2) and the watchdog
// (TIMEOUT=8, active only when SEQ_DET_TIMEOUT_EN is defined).

module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_overlap, start, stop, x, x_valid, evt_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       m_cr, m_ce, m_bz, m_m, m_ov, m_ev, m_to;
  logic [7:0] m_mc, m_ec;
  logic       s_cr, s_ce, s_bz, s_m, s_ov, s_ev, s_to;
  logic [1:0] s_mc, s_ec;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TIMEOUT(64)) u_main (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(m_cr),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(m_ce), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .busy(m_bz), .match(m_m), .match_count(m_mc), .overflow(m_ov),
    .evt_valid(m_ev), .evt_ready(evt_ready), .evt_count(m_ec), .timeout(m_to)
  );

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2), .TIMEOUT(8)) u_small (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(s_cr),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(s_ce), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .busy(s_bz), .match(s_m), .match_count(s_mc), .overflow(s_ov),
    .evt_valid(s_ev), .evt_ready(evt_ready), .evt_count(s_ec), .timeout(s_to)
  );

  typedef struct packed {
    logic       rst, cv;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, st, sp, xb, xv, er;
    logic       cr, ce, bz, m;
    logic [7:0] mc;
    logic       of, ev;
    logic [7:0] ec;
  } vec_t;

  function automatic vec_t row(input int rs, cv, pt, ln, ov, st, sp, xb, xv, er,
                               cr, ce, bz, m, mc, of, ev, ec);
    vec_t r;
    r.rst = 1'(rs); r.cv = 1'(cv); r.pat = 8'(pt); r.len = 4'(ln);
    r.ovl = 1'(ov); r.st = 1'(st); r.sp = 1'(sp); r.xb = 1'(xb);
    r.xv  = 1'(xv); r.er = 1'(er);
    r.cr = 1'(cr); r.ce = 1'(ce); r.bz = 1'(bz); r.m = 1'(m);
    r.mc = 8'(mc); r.of = 1'(of); r.ev = 1'(ev); r.ec = 8'(ec);
    return r;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, cv, input logic [7:0] pt, input logic [3:0] ln,
                       input logic ov, st, sp, xb, xv, er);
    rst = rs; cfg_valid = cv; cfg_pattern = pt; cfg_len = ln; cfg_overlap = ov;
    start = st; stop = sp; x = xb; x_valid = xv; evt_ready = er;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    //                rst cv pat  len ov st sp x xv er | cr ce bz m mc of ev ec
    tbl.push_back(row(1, 0, 0,    0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 0,    0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    // overlapping 1001, stream 1001001
    tbl.push_back(row(0, 1, 8'h09,4, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 2, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 2, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 2, 0, 0, 1));
    // non-overlapping, config + start together
    tbl.push_back(row(0, 1, 8'h09,4, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 1, 0, 1, 0,   1, 0, 0, 0, 1, 0, 1, 1));
    // illegal lengths; old config kept
    tbl.push_back(row(0, 1, 8'hFF,1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(row(0, 1, 8'hFF,9, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 1, 0, 1, 1));
    // event held over further matches
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 2, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 2, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 3, 0, 1, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 3, 0, 0, 1));
    // new event, then hit coinciding with acceptance
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 3, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 3, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 3, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 4, 0, 1, 4));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 4, 0, 1, 4));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 4, 0, 1, 4));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 4, 0, 1, 4));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 1,   0, 0, 1, 1, 5, 0, 1, 5));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 5, 0, 0, 5));
    // start in RUN ignored; stop together with completing bit
    tbl.push_back(row(0, 0, 0,    0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 5, 0, 0, 5));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 5, 0, 0, 5));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 5, 0, 0, 5));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 5, 0, 0, 5));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 1, 1, 1, 0,   1, 0, 0, 1, 6, 0, 1, 6));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 6, 0, 0, 6));
    tbl.push_back(row(0, 0, 0,    0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 6));
    tbl.push_back(row(0, 0, 0,    0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 6));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(t.rst, t.cv, t.pat, t.len, t.ovl, t.st, t.sp, t.xb, t.xv, t.er);
      chk($sformatf("row%0d.cfg_ready", i),   m_cr, t.cr);
      chk($sformatf("row%0d.cfg_err", i),     m_ce, t.ce);
      chk($sformatf("row%0d.busy", i),        m_bz, t.bz);
      chk($sformatf("row%0d.match", i),       m_m,  t.m);
      chk($sformatf("row%0d.match_count", i), m_mc, t.mc);
      chk($sformatf("row%0d.overflow", i),    m_ov, t.of);
      chk($sformatf("row%0d.evt_valid", i),   m_ev, t.ev);
      chk($sformatf("row%0d.evt_count", i),   m_ec, t.ec);
      chk($sformatf("row%0d.timeout", i),     m_to, 0);
    end

    // Saturation on the CNT_W=2 instance: pattern 11, overlapping, six 1s -> 5 hits
    drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
    chk("sat.reset_count", s_mc, 0);
    chk("sat.reset_ovf", s_ov, 0);
    drive(0, 1, 8'h03, 4'd2, 1, 1, 0, 0, 0, 0);
    chk("sat.busy", s_bz, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 1, 0);
    chk("sat.count_after_3", s_mc, 3);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 1, 0);
    chk("sat.match_5th", s_m, 1);
    chk("sat.count_held", s_mc, 3);
    chk("sat.overflow", s_ov, 1);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
    chk("sat.overflow_sticky", s_ov, 1);
    chk("sat.match_clear", s_m, 0);

    // Watchdog on the TIMEOUT=8 instance: all-zero stream against 1001
    drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 8'h09, 4'd4, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 1, 0);
    chk("wd.busy_before", s_bz, 1);
    chk("wd.timeout_before", s_to, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 1, 0);
`ifdef SEQ_DET_TIMEOUT_EN
    chk("wd.timeout_pulse", s_to, 1);
    chk("wd.busy_after", s_bz, 0);
`else
    chk("wd.timeout_tied", s_to, 0);
    chk("wd.busy_kept", s_bz, 1);
`endif
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
    chk("wd.timeout_one_cycle", s_to, 0);
`ifdef SEQ_DET_TIMEOUT_EN
    chk("wd.idle", s_cr, 1);
`else
    chk("wd.still_run", s_cr, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
